// File: rtl/xub_nibble_packer.sv
// xub_nibble_packer: packs 4-bit beats into ROWS*12-bit words behind valid/ready links.
// Optional X check on incoming beats enabled by defining XUB_PACKER_XCHK_EN.
module xub_nibble_packer #(
  parameter int ROWS = 4,
  parameter int CNT_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_nib,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS-1:0][2:2][2:4][4:1] out_word,
  output logic [CNT_W-1:0]              word_cnt,
  output logic                          x_err
);
  localparam int BEATS = ROWS * 3;
  localparam int W = ROWS * 12;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic {FILL, STALL} state_t;
  state_t state;
  logic [BW-1:0] beat_idx;
  logic [W-1:0] asm_q, asm_nx;
  logic fire, bad, take, free;
  assign fire = in_valid && in_ready;
  assign take = fire && !bad && !flush;
  assign free = !out_valid || out_ready;
  always_comb begin
    asm_nx = asm_q;
    asm_nx[4*beat_idx +: 4] = in_nib;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      beat_idx <= '0;
      asm_q <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_word <= '0;
      word_cnt <= '0;
    end else begin
      if (out_valid && out_ready) word_cnt <= word_cnt + CNT_W'(1);
      if (out_ready) out_valid <= 1'b0;
      // flush drops the partial word and any word parked in STALL
      if (flush) begin
        state <= FILL;
        in_ready <= 1'b1;
        beat_idx <= '0;
      end else if (state == STALL) begin
        if (out_ready) begin
          out_word <= asm_q;
          out_valid <= 1'b1;
          beat_idx <= '0;
          state <= FILL;
          in_ready <= 1'b1;
        end
      end else if (take) begin
        asm_q <= asm_nx;
        if (beat_idx != LAST) beat_idx <= beat_idx + BW'(1);
        else if (free) begin
          out_word <= asm_nx;
          out_valid <= 1'b1;
          beat_idx <= '0;
        end else begin
          state <= STALL;
          in_ready <= 1'b0;
        end
      end
    end
`ifdef XUB_PACKER_XCHK_EN
  assign bad = $isunknown(in_nib);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) x_err <= 1'b0;
    else if (fire && bad) x_err <= 1'b1;
`else
  assign bad = 1'b0;
  assign x_err = 1'b0;
`endif
endmodule

// File: tb/tb_xub_nibble_packer.sv
// tb_xub_nibble_packer: scoreboard bench for xub_nibble_packer with a queue-based reference model.
module tb_xub_nibble_packer;
  localparam int BEATS = 12;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, x_err;
  logic [3:0] in_nib;
  logic [3:0][2:2][2:4][4:1] out_word;
  logic [63:0] word_cnt;
  int checks = 0;
  int failures = 0;
  logic [3:0] beats[$];
  logic [47:0] expq[$];
  logic [47:0] hw, w, e;
  logic [63:0] cnt;
  bit held, slot, xe, xb, free;

  xub_nibble_packer #(.ROWS(4), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_nib(in_nib), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .word_cnt(word_cnt), .x_err(x_err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: evaluated at negedge on the values the next posedge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      beats.delete();
      expq.delete();
      held = 0;
      slot = 0;
      xe = 0;
      cnt = 0;
    end else begin
      check(in_ready === !held, "in_ready", 64'(in_ready), 64'(!held));
      check(out_valid === slot, "out_valid", 64'(out_valid), 64'(slot));
      check(word_cnt === cnt, "word_cnt", word_cnt, cnt);
      check(x_err === xe, "x_err", 64'(x_err), 64'(xe));
`ifdef XUB_PACKER_XCHK_EN
      xb = $isunknown(in_nib);
`else
      xb = 0;
`endif
      free = !slot || out_ready;
      if (slot && out_ready) begin
        slot = 0;
        cnt++;
      end
      if (in_valid && !held && xb) xe = 1;
      if (flush) begin
        beats.delete();
        held = 0;
      end else if (held) begin
        if (out_ready) begin
          expq.push_back(hw);
          slot = 1;
          held = 0;
        end
      end else if (in_valid) begin
        if (!xb) beats.push_back(in_nib);
        if (beats.size() == BEATS) begin
          w = '0;
          for (int k = 0; k < BEATS; k++) w[4*k +: 4] = beats[k];
          beats.delete();
          if (free) begin
            expq.push_back(w);
            slot = 1;
          end else begin
            hw = w;
            held = 1;
          end
        end
      end
    end
  end

  // Monitor: every consumed word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) check(1'b0, "word_unexpected", 64'(out_word), 64'h0);
      else begin
        e = expq.pop_front();
        check(out_word === e, "word", 64'(out_word), 64'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_nib = n;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check(1'b0, "send_timeout", 64'(t), 64'd200);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_nib = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check(out_word === 48'h0, "rst_word", 64'(out_word), 64'h0);
    check(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'h1);
    check(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'h0);
    check(word_cnt === 64'h0, "rst_cnt", word_cnt, 64'h0);
    // ascending nibbles, back to back
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(4'(i));
    in_valid = 1'b0;
    check(out_valid === 1'b1, "t1_valid", 64'(out_valid), 64'h1);
    check(out_word === 48'hBA9876543210, "t1_word", 64'(out_word), 64'hBA9876543210);
    step();
    check(word_cnt === 64'd1, "t1_cnt", word_cnt, 64'd1);
    // two words against a blocked sink
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(4'($urandom));
    in_valid = 1'b0;
    check(in_ready === 1'b0, "t2_stall", 64'(in_ready), 64'h0);
    check(out_valid === 1'b1, "t2_valid", 64'(out_valid), 64'h1);
    step();
    step();
    out_ready = 1'b1;
    repeat (3) step();
    check(word_cnt === 64'd2, "t2_cnt", word_cnt, 64'd2);
    check(out_valid === 1'b0, "t2_drained", 64'(out_valid), 64'h0);
    // flush a partial word; the beat offered with flush is discarded too
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(4'($urandom));
    flush = 1'b1;
    in_valid = 1'b1;
    in_nib = 4'h7;
    step();
    flush = 1'b0;
    for (int i = 0; i < 12; i++) send(4'hF);
    in_valid = 1'b0;
    check(out_word === 48'hFFFFFFFFFFFF, "t3_word", 64'(out_word), 64'hFFFFFFFFFFFF);
    step();
    step();
    check(word_cnt === 64'd1, "t3_cnt", word_cnt, 64'd1);
    // asynchronous reset while a word sits in STALL
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(4'($urandom));
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(4'($urandom));
    in_valid = 1'b0;
    check(in_ready === 1'b0, "t4_stall", 64'(in_ready), 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check(out_valid === 1'b0, "t4_async_valid", 64'(out_valid), 64'h0);
    check(in_ready === 1'b1, "t4_async_ready", 64'(in_ready), 64'h1);
    check(word_cnt === 64'h0, "t4_async_cnt", word_cnt, 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
`ifdef XUB_PACKER_XCHK_EN
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) send(i == 3 ? 4'bx1z0 : 4'h5);
    in_valid = 1'b0;
    check(x_err === 1'b1, "t5_xerr", 64'(x_err), 64'h1);
    check(out_word === 48'h555555555555, "t5_word", 64'(out_word), 64'h555555555555);
`else
    check(x_err === 1'b0, "t5_xerr_tied", 64'(x_err), 64'h0);
`endif
    // randomized traffic with occasional flushes and sink back-pressure phases
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_nib = 4'($urandom);
      out_ready = ((i / 200) % 2) != 0 ? $urandom_range(0, 1) != 0 : $urandom_range(0, 7) != 0;
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check(expq.size() == 0, "drain", 64'(expq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
